// File: rtl/gps_uart_rx.sv
// 8N1 serial receiver for the GPS NMEA stream: synchronises rx, finds the start edge,
// samples each bit at mid-bit and emits one character per frame with valid/error strobes.
module gps_uart_rx #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           rx_meta;
  logic           rx_s;
  logic           rx_p;
  logic [1:0]     settle_cnt;
  logic           start_edge;

  // Start edges are ignored until rx_p holds a real line sample rather than a reset value,
  // so a line that is low when reset releases cannot fake a falling edge.
  assign start_edge = (settle_cnt == 2'd3) && rx_p && !rx_s;

  // Two-flop synchroniser, one-cycle delayed copy for edge detection, and post-reset settle count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_p       <= 1'b0;
      settle_cnt <= 2'd0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_p    <= rx_s;
      if (settle_cnt != 2'd3) begin
        settle_cnt <= settle_cnt + 2'd1;
      end else begin
        settle_cnt <= settle_cnt;
      end
    end
  end

  // Frame FSM with registered character, strobes and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_edge) begin
            state <= START;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        START: begin
          if (cnt == CNT_HALF_END) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_BIT_END) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit gives half a bit of slack for a back-to-back start edge.
          if (cnt == CNT_BIT_END) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_s) begin
              data       <= shreg;
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gps_uart_rx.sv
// Directed and randomized bench for gps_uart_rx: frames are generated bit by bit and every
// strobe is checked for cycle, kind and character against an arithmetic frame model.
module tb_gps_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  localparam int SYNC = 2;
  localparam int LAT  = HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  gps_uart_rx #(.CLK_HZ(160_000), .BAUD(10_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data),
    .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       err;
    logic [7:0] d;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  int         exp_rd = 0;
  int         obs_rd = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         viol = 0;
  logic       prev_pulse = 1'b0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] gpgll [5] = '{8'h47, 8'h50, 8'h47, 8'h4C, 8'h4C};

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe; count overlapping or back-to-back strobes.
  always @(negedge clk) begin
    if (data_valid || frame_err) obs_q.push_back('{cyc, frame_err, data});
    viol <= viol + ((data_valid && frame_err) ? 1 : 0)
                 + (((data_valid || frame_err) && prev_pulse) ? 1 : 0);
    prev_pulse <= data_valid || frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge with the line high; predicts the strobe, then drives the frame.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    ev_t e;
    e.cyc = cyc + SYNC + LAT;
    e.err = ~stop_bit;
    e.d   = stop_bit ? b : last_good;
    if (stop_bit) last_good = b;
    exp_q.push_back(e);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic compare_events(input string tag);
    int n_obs;
    int n_exp;
    repeat (2) @(negedge clk);
    n_obs = obs_q.size() - obs_rd;
    n_exp = exp_q.size() - exp_rd;
    chk({tag, "_count"}, 32'(n_obs), 32'(n_exp));
    for (int i = 0; i < n_obs && i < n_exp; i++) begin
      chk({tag, "_cycle"}, 32'(obs_q[obs_rd + i].cyc), 32'(exp_q[exp_rd + i].cyc));
      chk({tag, "_kind"},  32'(obs_q[obs_rd + i].err), 32'(exp_q[exp_rd + i].err));
      chk({tag, "_data"},  32'(obs_q[obs_rd + i].d),   32'(exp_q[exp_rd + i].d));
    end
    obs_rd = obs_q.size();
    exp_rd = exp_q.size();
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    logic       prev_stop;
    int         waited;
    logic [7:0] part;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(data), 32'h0);
    chk("reset_valid", 32'(data_valid), 32'h0);
    chk("reset_err", 32'(frame_err), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(8);

    send_byte(8'h24, 1'b1);
    compare_events("dollar");
    chk("dollar_data_port", 32'(data), 32'h24);

    for (int i = 0; i < 5; i++) send_byte(gpgll[i], 1'b1);
    compare_events("gpgll");

    idle(20);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy_set", 32'(busy), 32'h1);
    waited = 0;
    while (busy !== 1'b0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("glitch_busy_clear", 32'(busy), 32'h0);
    idle(40);
    compare_events("glitch");
    send_byte(8'h2C, 1'b1);
    compare_events("comma");

    idle(4);
    send_byte(8'h41, 1'b0);
    repeat (40 * CPB) @(negedge clk);
    compare_events("stop_err");
    chk("err_keeps_data", 32'(data), 32'h2C);
    idle(20);
    send_byte(8'h4E, 1'b1);
    compare_events("after_break");

    idle(10);
    part = 8'h53;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = part[i];
      repeat (CPB) @(negedge clk);
    end
    rx = part[3];
    repeat (CPB / 2) @(negedge clk);
    chk("mid_frame_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    chk("rst_mid_data", 32'(data), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_valid", 32'(data_valid), 32'h0);
    idle(200);
    compare_events("rst_mid");
    send_byte(8'h2A, 1'b1);
    compare_events("star");

    idle(4);
    rst = 1'b1;
    rx  = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (3 * CPB) @(negedge clk);
    chk("low_line_busy", 32'(busy), 32'h0);
    idle(2 * CPB);
    compare_events("low_after_rst");
    send_byte(8'h0A, 1'b1);
    compare_events("lf");

    prev_stop = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rb = 8'($urandom());
      rs = ($urandom_range(3, 0) != 0);
      if (!prev_stop) idle(CPB);
      else idle($urandom_range(20, 0));
      send_byte(rb, rs);
      prev_stop = rs;
    end
    idle(4);
    compare_events("random");

    chk("exclusive_pulses", 32'(viol), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
